// File: rtl/mpmc11_sc_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_sc_checker_if
// Brief    : Request, reservation-table, forward and status bundle for the
//            mpmc11 store-conditional checker.
// Revision : 1.0  initial release
// ============================================================================
interface mpmc11_sc_checker_if #(
    parameter int NAR = 2
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_ch;
    logic              req_we;
    logic              req_cr;
    logic [31:0]       req_adr;

    logic [4*NAR-1:0]  resv_ch;
    logic [32*NAR-1:0] resv_adr;

    logic              fwd_valid;
    logic              fwd_ready;
    logic [3:0]        fwd_ch;
    logic              fwd_we;
    logic              fwd_cr;
    logic [31:0]       fwd_adr;

    logic [7:0]        sc_done;
    logic [7:0]        sc_ok;
    logic [7:0]        sc_ack;
    logic [15:0]       sc_fail_cnt;

    modport slave (
        input  req_valid, req_ch, req_we, req_cr, req_adr,
        input  resv_ch, resv_adr, fwd_ready, sc_ack,
        output req_ready, fwd_valid, fwd_ch, fwd_we, fwd_cr, fwd_adr,
        output sc_done, sc_ok, sc_fail_cnt
    );

    modport master (
        output req_valid, req_ch, req_we, req_cr, req_adr,
        output resv_ch, resv_adr, fwd_ready, sc_ack,
        input  req_ready, fwd_valid, fwd_ch, fwd_we, fwd_cr, fwd_adr,
        input  sc_done, sc_ok, sc_fail_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mpmc11_sc_checker.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_sc_checker
// Brief    : Gates store-conditional writes against the reservation table and
//            reports per-channel success/fail status.
// Revision : 1.0  initial release
// ============================================================================
module mpmc11_sc_checker #(
    parameter int NAR      = 2,
    parameter int KILL_CYC = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    mpmc11_sc_checker_if.slave    bus
);
    localparam int         c_kcw      = $clog2(KILL_CYC + 1);
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_check = 2'd1;
    localparam logic [1:0] c_st_fwd   = 2'd2;

    logic [1:0]       r_state, w_state_nxt;
    logic             r_init;
    logic [3:0]       r_ch;
    logic             r_we, r_cr;
    logic [31:0]      r_adr;
    logic             r_kill_v;
    logic [3:0]       r_kill_ch;
    logic [27:0]      r_kill_gran;
    logic [c_kcw-1:0] r_kill_cnt;
    logic [7:0]       r_done, r_ok;
    logic [15:0]      r_fail_cnt;

    logic             w_req_stall, w_req_ready, w_accept;
    logic             w_is_cw, w_hit, w_kill_hit, w_fail, w_fwd_hs, w_set_ok;
    logic [NAR-1:0]   w_bucket_hit;
    logic [7:0]       w_set, w_done_nxt, w_ok_nxt;

    // Only channels 0-7 carry status, so only they can be held off.
    assign w_req_stall = bus.req_we & bus.req_cr & ~bus.req_ch[3] & r_done[bus.req_ch[2:0]];
    assign w_req_ready = (r_state == c_st_idle) & ~rst & ~r_init & ~w_req_stall;
    assign w_is_cw     = r_we & r_cr;

    for (genvar n = 0; n < NAR; n++) begin : g_bucket
        assign w_bucket_hit[n] = (bus.resv_ch[n*4 +: 4] == r_ch) &&
            (((bus.resv_adr[n*32 +: 32] ^ r_adr) & 32'hFFFF_FFF0) == 32'h0);
    end

    assign w_hit      = |w_bucket_hit;
    assign w_kill_hit = r_kill_v && (r_kill_ch == r_ch) && (r_kill_gran == r_adr[31:4]);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fail      = 1'b0;
        w_fwd_hs    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (bus.req_valid && w_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_st_check;
                end
            end
            c_st_check: begin
                if (w_is_cw && (r_ch[3] || !w_hit || w_kill_hit)) begin
                    w_fail      = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_state_nxt = c_st_fwd;
                end
            end
            c_st_fwd: begin
                if (bus.fwd_ready) begin
                    w_fwd_hs    = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // A status set in the same cycle as its ack takes priority.
    always_comb begin
        w_set    = 8'h00;
        w_set_ok = 1'b0;
        if (w_fail && !r_ch[3]) begin
            w_set = 8'd1 << r_ch[2:0];
        end
        if (w_fwd_hs && w_is_cw) begin
            w_set    = 8'd1 << r_ch[2:0];
            w_set_ok = 1'b1;
        end
        w_done_nxt = (r_done & ~bus.sc_ack) | w_set;
        w_ok_nxt   = (r_ok & ~bus.sc_ack & ~w_set) | (w_set & {8{w_set_ok}});
    end

    always_ff @(posedge clk) begin
        r_init <= rst;
        if (rst) begin
            r_state     <= c_st_idle;
            r_ch        <= 4'h0;
            r_we        <= 1'b0;
            r_cr        <= 1'b0;
            r_adr       <= 32'h0;
            r_kill_v    <= 1'b0;
            r_kill_ch   <= 4'h0;
            r_kill_gran <= 28'h0;
            r_kill_cnt  <= '0;
            r_done      <= 8'h00;
            r_ok        <= 8'h00;
            r_fail_cnt  <= 16'h0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_ok    <= w_ok_nxt;
            if (w_accept) begin
                r_ch  <= bus.req_ch;
                r_we  <= bus.req_we;
                r_cr  <= bus.req_cr;
                r_adr <= bus.req_adr;
            end
            if (w_fail && (r_fail_cnt != 16'hFFFF)) begin
                r_fail_cnt <= r_fail_cnt + 16'd1;
            end
            // Blacklist the granule until the manager has cleared its bucket.
            if (w_fwd_hs && w_is_cw) begin
                r_kill_v    <= 1'b1;
                r_kill_ch   <= r_ch;
                r_kill_gran <= r_adr[31:4];
                r_kill_cnt  <= c_kcw'(KILL_CYC);
            end else if (r_kill_v) begin
                r_kill_cnt <= r_kill_cnt - 1'b1;
                if (r_kill_cnt == c_kcw'(1)) begin
                    r_kill_v <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.fwd_valid   = (r_state == c_st_fwd);
    assign bus.fwd_ch      = r_ch;
    assign bus.fwd_we      = r_we;
    assign bus.fwd_cr      = r_cr;
    assign bus.fwd_adr     = r_adr;
    assign bus.sc_done     = r_done;
    assign bus.sc_ok       = r_ok;
    assign bus.sc_fail_cnt = r_fail_cnt;
endmodule
`default_nettype wire

// File: doc/mpmc11_sc_checker.md
# mpmc11_sc_checker

Conditional-store gate between the channel request arbiter and the mpmc11 memory state machine. It checks every store-conditional write against the address reservation table before the write reaches DRAM. It drops writes whose reservation is missing and forwards the rest unchanged. It reports a per-channel success/fail status to the requesting channels.

## Interface
- NAR, 2, number of reservation buckets; must match the reservation manager.
- KILL_CYC, 4, cycles a granule/channel pair stays blacklisted after a successful conditional write is forwarded.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  block accepts request this cycle.
- req_ch  in  4  requesting channel.
- req_we  in  1  write request.
- req_cr  in  1  conditional (store-conditional) write; ignored when req_we=0.
- req_adr  in  32  byte address.
- resv_ch  in  4 x NAR  reservation bucket owners; 4'hF means empty.
- resv_adr  in  32 x NAR  reservation bucket addresses.
- fwd_valid  out  1  forwarded request valid.
- fwd_ready  in  1  memory state machine takes the forwarded request.
- fwd_ch, fwd_we, fwd_cr, fwd_adr  out  4/1/1/32  forwarded copy of the request.
- sc_done  out  8  per-channel status valid, sticky until acknowledged.
- sc_ok  out  8  per-channel result: 1 = conditional store performed.
- sc_ack  in  8  per-channel status acknowledge.
- sc_fail_cnt  out  16  saturating count of failed conditional writes.

## Operation
- Request classes:
  - Reads and plain writes (req_we=0, or req_cr=0) are forwarded unchanged and generate no status.
  - A conditional write is one with req_we=1 and req_cr=1.
- Hit rule for a conditional write: some bucket n has resv_ch[n]==ch and resv_adr[n][31:4]==adr[31:4]. Compare on the 16-byte granule; ignore bits [3:0].
- Kill entry: {valid, ch, granule, count}.
  - Loaded on every successful conditional-write forward handshake, with count=KILL_CYC.
  - count decrements each cycle; valid clears at 0.
  - A conditional write matching a valid kill entry's ch and granule fails even on a table hit. This covers the window before the manager clears the bucket.
- Channel range: a conditional write with req_ch[3]=1 always fails, produces no status, and increments sc_fail_cnt.
- States:
  - IDLE. req_ready = ~(req_we & req_cr & ~req_ch[3] & sc_done[req_ch[2:0]]). A handshake captures the request and moves to CHECK.
  - CHECK, 1 cycle. Evaluates the hit and kill rules combinationally against the current resv_* inputs.
    - Plain request or conditional hit: go to FWD.
    - Conditional fail: sc_done[ch]<=1, sc_ok[ch]<=0, increment sc_fail_cnt (saturating at 16'hFFFF), go to IDLE.
  - FWD. fwd_valid=1 with the captured fields held stable until fwd_ready.
    - On handshake of a conditional write: sc_done[ch]<=1, sc_ok[ch]<=1, load the kill entry, go to IDLE.
    - On handshake of any other request: go to IDLE.
- sc_ack[i] clears sc_done[i] and sc_ok[i]. If a status set and its ack occur for the same channel in the same cycle, the set wins.
- A channel with sc_done pending cannot issue another conditional write; it is stalled via req_ready=0. Its other request types are not stalled.

## Timing
- Reset values (while rst=1 and on the cycle after): state IDLE, req_ready=0, fwd_valid=0, sc_done=0, sc_ok=0, sc_fail_cnt=0, kill entry invalid.
- Reset mid-operation discards the in-flight request with no status and no forward.
- Request accepted at edge T:
  - Plain request or conditional hit: fwd_valid rises at T+1. For a conditional write, status appears 1 cycle after the fwd handshake.
  - Conditional fail: sc_done/sc_ok visible at T+1. req_ready may be high again in cycle T+1.
- Peak throughput: 1 request per 3 cycles with fwd_ready=1.
- resv_* inputs are sampled only in CHECK. Later table changes do not affect a request already in FWD.
- fwd_* fields are stable while fwd_valid=1 and fwd_ready=0.

## Test plan
- Table ch2 / 0x0000_1230; conditional write ch2 at 0x0000_123C, fwd_ready=1 -> fwd_valid at T+1, sc_done[2]=1 and sc_ok[2]=1 one cycle after the handshake.
- Same table; conditional write ch3 at 0x0000_1230 -> no fwd_valid, sc_done[3]=1, sc_ok[3]=0, sc_fail_cnt=1.
- Successful conditional write ch2 at 0x1230; repeat it 2 cycles after the ack with the table unchanged -> second write fails (kill). Repeat after KILL_CYC+1 cycles -> succeeds.
- sc_done[1] pending; present a conditional write on ch1 then a read on ch1 -> req_ready=0 for the write; read accepted after ack. Assert sc_ack[1] in the same cycle as a new status set -> sc_done[1] stays 1.
- fwd_ready=0 for 5 cycles during a plain write -> fwd_* stable and unchanged; reset asserted in cycle 3 -> fwd_valid=0 next cycle, no status.
- 65540 forced failures -> sc_fail_cnt saturates at 16'hFFFF. Conditional write with req_ch=4'hF -> count increments, sc_done unchanged.
